// File: rtl/router_pkg.sv
// router_pkg -- shared types and constants for the router control slice.
//
// Contents:
//   state_e          : control FSM state encoding
//   ADDR_INVALID     : header address that names no channel (packet dropped)
//   TIMEOUT_DEFAULT  : default idle-valid cycle count before a channel flush
//   addr_onehot()    : channel address -> one-hot channel vector
//   chan_bit()       : select one channel's bit from a 3-bit vector by address
//
// Optional feature: ROUTER_SOFT_RESET_EN (used by router_ctrl) enables the
// per-channel timeout flush.

package router_pkg;

  typedef enum logic [2:0] {
    DECODE,
    WAIT_EMPTY,
    LFD,
    LOAD_DATA,
    FIFO_FULL,
    LAF,
    LOAD_PARITY,
    CHECK_PARITY
  } state_e;

  localparam logic [1:0] ADDR_INVALID    = 2'b11;
  localparam int         TIMEOUT_DEFAULT = 30;

  // Address 3 maps to no channel, so it yields an all-zero vector.
  function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
    logic [2:0] vec;
    case (addr)
      2'b00:   vec = 3'b001;
      2'b01:   vec = 3'b010;
      2'b10:   vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

  // Explicit decode keeps the out-of-range address 3 well defined (reads 0).
  function automatic logic chan_bit(input logic [2:0] vec, input logic [1:0] addr);
    logic bit_sel;
    case (addr)
      2'b00:   bit_sel = vec[0];
      2'b01:   bit_sel = vec[1];
      2'b10:   bit_sel = vec[2];
      default: bit_sel = 1'b0;
    endcase
    return bit_sel;
  endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// router_timeout_ctr -- idle-valid watchdog for one output channel.
//
// Counts cycles where the channel holds data (vld_i) that nobody reads
// (read_i low). When the count reaches TIMEOUT-1 the next edge raises
// soft_reset_o for exactly one cycle and restarts the count. Any read or an
// empty channel clears the count.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   vld_i        : channel FIFO holds data
//   read_i       : downstream read strobe for the channel
//   soft_reset_o : registered one-cycle flush pulse

module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic vld_i,
  input  logic read_i,
  output logic soft_reset_o
);

  localparam int              CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;
  logic          soft_reset_q, soft_reset_d;

  // Next count: clear on read or empty channel, wrap with a pulse at LAST,
  // otherwise keep counting idle cycles.
  always_comb begin
    count_d      = count_q + CW'(1);
    soft_reset_d = 1'b0;
    if (!vld_i || read_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d      = '0;
      soft_reset_d = 1'b1;
    end
  end

  // Count and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset_o = soft_reset_q;

endmodule

// File: rtl/router_ctrl.sv
// router_ctrl -- packet router control FSM.
//
// Decodes the header address of an incoming packet, waits for the target
// channel FIFO to drain, then steers FIFO writes through header, payload and
// parity phases, pausing while the target FIFO is full.
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   pkt_valid, data_in  : packet byte valid, header address bits
//   fifo_full_in        : per-channel FIFO full
//   fifo_empty          : per-channel FIFO empty
//   read_enb            : per-channel downstream read strobe
//   parity_done         : packet register finished parity
//   low_pkt_valid       : packet register saw pkt_valid fall
//   fifo_full           : full flag of the latched channel
//   write_enb           : one-hot FIFO write enable
//   vld_out             : per-channel data available
//   soft_reset          : per-channel timeout flush pulse
//   detect_add .. busy  : state decodes
//
// Build option: define ROUTER_SOFT_RESET_EN to include the per-channel
// timeout timers and the soft-reset return to DECODE. Without it soft_reset
// is tied low and the timers are absent.

module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full_in,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       fifo_full,
  output logic [2:0] write_enb,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       soft_reset_hit;

  assign vld_out = ~fifo_empty;

`ifdef ROUTER_SOFT_RESET_EN
  // One independent watchdog per channel; a flush on the latched channel
  // abandons the packet in progress.
  for (genvar ch = 0; ch < 3; ch++) begin : g_timer
    router_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .vld_i        (vld_out[ch]),
      .read_i       (read_enb[ch]),
      .soft_reset_o (soft_reset[ch])
    );
  end
  assign soft_reset_hit = chan_bit(soft_reset, addr_q);
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_read_enb;
  assign unused_read_enb = ^read_enb;
  assign soft_reset      = 3'b000;
  assign soft_reset_hit  = 1'b0;
`endif

  assign fifo_full = chan_bit(fifo_full_in, addr_q);

  // Next-state and address-latch logic. A flush of the latched channel
  // overrides every other transition.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DECODE && pkt_valid && data_in != ADDR_INVALID) begin
      addr_d = data_in;
    end
    if (soft_reset_hit) begin
      state_d = DECODE;
    end else begin
      case (state_q)
        DECODE: begin
          if (pkt_valid && data_in != ADDR_INVALID) begin
            state_d = chan_bit(fifo_empty, data_in) ? LFD : WAIT_EMPTY;
          end
        end
        WAIT_EMPTY: begin
          if (chan_bit(fifo_empty, addr_q)) state_d = LFD;
        end
        LFD: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL: begin
          if (!fifo_full) state_d = LAF;
        end
        LAF: begin
          if (parity_done)        state_d = DECODE;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:  state_d = CHECK_PARITY;
        CHECK_PARITY: state_d = fifo_full ? FIFO_FULL : DECODE;
        default:      state_d = DECODE;
      endcase
    end
  end

  // State and latched-address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DECODE;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add  = (state_q == DECODE);
  assign lfd_state   = (state_q == LFD);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LAF);
  assign full_state  = (state_q == FIFO_FULL);
  assign rst_int_reg = (state_q == CHECK_PARITY);
  assign busy        = !(state_q == DECODE || state_q == LOAD_DATA);

  // Writes happen only in payload, resume-after-full and parity phases.
  assign write_enb = (state_q == LOAD_DATA || state_q == LAF || state_q == LOAD_PARITY)
                     ? addr_onehot(addr_q) : 3'b000;

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl -- directed self-checking bench for router_ctrl.
// Timer scenarios are exercised when ROUTER_SOFT_RESET_EN is defined;
// otherwise the bench confirms soft_reset stays low.

module tb_router_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pktValid;
  logic [1:0] dataIn;
  logic [2:0] fifoFullIn;
  logic [2:0] fifoEmpty;
  logic [2:0] readEnb;
  logic       parityDone;
  logic       lowPktValid;
  logic       fifoFull;
  logic [2:0] writeEnb;
  logic [2:0] vldOut;
  logic [2:0] softReset;
  logic       detectAdd, lfdState, ldState, lafState, fullState, rstIntReg, busy;

  int checks   = 0;
  int failures = 0;

  // Decode groups: {detect_add, lfd, ld, laf, full, rst_int_reg, busy}
  localparam logic [6:0] S_DEC  = 7'b1000000;
  localparam logic [6:0] S_WAIT = 7'b0000001;
  localparam logic [6:0] S_LFD  = 7'b0100001;
  localparam logic [6:0] S_LD   = 7'b0010000;
  localparam logic [6:0] S_FF   = 7'b0000101;
  localparam logic [6:0] S_LAF  = 7'b0001001;
  localparam logic [6:0] S_LP   = 7'b0000001;
  localparam logic [6:0] S_CP   = 7'b0000011;

  typedef struct {
    string      name;
    logic       pv;
    logic [1:0] din;
    logic [2:0] fullIn;
    logic [2:0] emptyIn;
    logic       pd;
    logic       low;
    logic [6:0] expState;
    logic       expFull;
    logic [2:0] expWe;
  } vec_t;

  vec_t vecs[$];

  router_ctrl #(
    .TIMEOUT (30)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_valid     (pktValid),
    .data_in       (dataIn),
    .fifo_full_in  (fifoFullIn),
    .fifo_empty    (fifoEmpty),
    .read_enb      (readEnb),
    .parity_done   (parityDone),
    .low_pkt_valid (lowPktValid),
    .fifo_full     (fifoFull),
    .write_enb     (writeEnb),
    .vld_out       (vldOut),
    .soft_reset    (softReset),
    .detect_add    (detectAdd),
    .lfd_state     (lfdState),
    .ld_state      (ldState),
    .laf_state     (lafState),
    .full_state    (fullState),
    .rst_int_reg   (rstIntReg),
    .busy          (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [10:0] outVec();
    return {detectAdd, lfdState, ldState, lafState, fullState, rstIntReg, busy,
            fifoFull, writeEnb};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic pv, input logic [1:0] din,
                             input logic [2:0] fullIn, input logic [2:0] emptyIn,
                             input logic [2:0] rd, input logic pd, input logic low);
    @(negedge clk);
    pktValid    = pv;
    dataIn      = din;
    fifoFullIn  = fullIn;
    fifoEmpty   = emptyIn;
    readEnb     = rd;
    parityDone  = pd;
    lowPktValid = low;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v.pv, v.din, v.fullIn, v.emptyIn, 3'b111, v.pd, v.low);
    stepEdge();
  endtask

  task automatic addVec(input string name, input logic pv, input logic [1:0] din,
                        input logic [2:0] fullIn, input logic [2:0] emptyIn,
                        input logic pd, input logic low, input logic [6:0] expState,
                        input logic expFull, input logic [2:0] expWe);
    vec_t v;
    v.name = name; v.pv = pv; v.din = din; v.fullIn = fullIn; v.emptyIn = emptyIn;
    v.pd = pd; v.low = low; v.expState = expState; v.expFull = expFull; v.expWe = expWe;
    vecs.push_back(v);
  endtask

  initial begin
    // Table: applied in order, outputs checked one edge later.
    addVec("addr3_drop",      1, 2'b11, 3'b001, 3'b111, 0, 0, S_DEC,  1, 3'b000);
    addVec("ch1_lfd",         1, 2'b01, 3'b000, 3'b111, 0, 0, S_LFD,  0, 3'b000);
    addVec("ch1_load",        1, 2'b01, 3'b000, 3'b111, 0, 0, S_LD,   0, 3'b010);
    addVec("ch1_full",        1, 2'b01, 3'b010, 3'b111, 0, 0, S_FF,   1, 3'b000);
    addVec("ch1_full_hold",   1, 2'b01, 3'b010, 3'b111, 0, 0, S_FF,   1, 3'b000);
    addVec("ch1_laf",         1, 2'b01, 3'b000, 3'b111, 0, 0, S_LAF,  0, 3'b010);
    addVec("ch1_laf_to_ld",   1, 2'b01, 3'b000, 3'b111, 0, 0, S_LD,   0, 3'b010);
    addVec("ch1_load_par",    0, 2'b01, 3'b000, 3'b111, 0, 0, S_LP,   0, 3'b010);
    addVec("ch1_check_par",   0, 2'b01, 3'b000, 3'b111, 0, 0, S_CP,   0, 3'b000);
    addVec("ch1_decode",      0, 2'b01, 3'b000, 3'b111, 0, 0, S_DEC,  0, 3'b000);
    addVec("ch0_wait",        1, 2'b00, 3'b000, 3'b110, 0, 0, S_WAIT, 0, 3'b000);
    addVec("ch0_wait_hold",   0, 2'b00, 3'b000, 3'b110, 0, 0, S_WAIT, 0, 3'b000);
    addVec("ch0_lfd",         0, 2'b00, 3'b000, 3'b111, 0, 0, S_LFD,  0, 3'b000);
    addVec("ch0_load",        1, 2'b00, 3'b000, 3'b111, 0, 0, S_LD,   0, 3'b001);
    addVec("ch0_load_par",    0, 2'b00, 3'b000, 3'b111, 0, 0, S_LP,   0, 3'b001);
    addVec("ch0_check_full",  0, 2'b00, 3'b001, 3'b111, 0, 0, S_CP,   1, 3'b000);
    addVec("ch0_cp_to_full",  0, 2'b00, 3'b001, 3'b111, 0, 0, S_FF,   1, 3'b000);
    addVec("ch0_laf",         0, 2'b00, 3'b000, 3'b111, 0, 0, S_LAF,  0, 3'b001);
    addVec("ch0_parity_done", 0, 2'b00, 3'b000, 3'b111, 1, 0, S_DEC,  0, 3'b000);
    addVec("ch2_lfd",         1, 2'b10, 3'b000, 3'b111, 0, 0, S_LFD,  0, 3'b000);
    addVec("ch2_load",        1, 2'b10, 3'b000, 3'b111, 0, 0, S_LD,   0, 3'b100);
    addVec("ch2_full",        1, 2'b10, 3'b100, 3'b111, 0, 0, S_FF,   1, 3'b000);
    addVec("ch2_laf",         1, 2'b10, 3'b000, 3'b111, 0, 0, S_LAF,  0, 3'b100);
    addVec("ch2_low_pkt",     1, 2'b10, 3'b000, 3'b111, 0, 1, S_LP,   0, 3'b100);
    addVec("ch2_check_par",   0, 2'b10, 3'b000, 3'b111, 0, 0, S_CP,   0, 3'b000);
    addVec("ch2_decode",      0, 2'b10, 3'b000, 3'b111, 0, 0, S_DEC,  0, 3'b000);

    reset = 1'b1; pktValid = 1'b0; dataIn = 2'b00; fifoFullIn = 3'b000;
    fifoEmpty = 3'b111; readEnb = 3'b111; parityDone = 1'b0; lowPktValid = 1'b0;
    stepEdge();
    stepEdge();
    checkOutput("reset_state", 32'(outVec()), 32'({S_DEC, 1'b0, 3'b000}));
    checkOutput("reset_soft", 32'(softReset), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, 32'(outVec()),
                  32'({vecs[i].expState, vecs[i].expFull, vecs[i].expWe}));
    end

    // Asynchronous reset in the middle of a payload on channel 2.
    driveInputs(1, 2'b10, 3'b000, 3'b111, 3'b111, 0, 0);
    stepEdge();
    driveInputs(1, 2'b10, 3'b000, 3'b111, 3'b111, 0, 0);
    stepEdge();
    checkOutput("pre_async_load", 32'(outVec()), 32'({S_LD, 1'b0, 3'b100}));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_now", 32'(outVec()), 32'({S_DEC, 1'b0, 3'b000}));
    driveInputs(0, 2'b10, 3'b000, 3'b111, 3'b111, 0, 0);
    reset = 1'b0;
    stepEdge();
    checkOutput("after_reset_idle", 32'(outVec()), 32'({S_DEC, 1'b0, 3'b000}));

`ifdef ROUTER_SOFT_RESET_EN
    // Channel 1 left unread: single pulse on the 30th edge.
    driveInputs(0, 2'b00, 3'b000, 3'b101, 3'b000, 0, 0);
    checkOutput("vld_out_ch1", 32'(vldOut), 32'h2);
    for (int e = 1; e <= 31; e++) begin
      stepEdge();
      checkOutput($sformatf("timeout_e%0d", e), 32'(softReset),
                  (e == 30) ? 32'h2 : 32'h0);
    end

    // A read on cycle 29 restarts the count: no pulse.
    driveInputs(0, 2'b00, 3'b000, 3'b111, 3'b111, 0, 0);
    stepEdge();
    driveInputs(0, 2'b00, 3'b000, 3'b101, 3'b000, 0, 0);
    for (int e = 1; e <= 28; e++) begin
      stepEdge();
    end
    checkOutput("read_e28", 32'(softReset), 32'h0);
    driveInputs(0, 2'b00, 3'b000, 3'b101, 3'b010, 0, 0);
    stepEdge();
    driveInputs(0, 2'b00, 3'b000, 3'b101, 3'b000, 0, 0);
    for (int e = 30; e <= 36; e++) begin
      stepEdge();
      checkOutput($sformatf("read_no_pulse_e%0d", e), 32'(softReset), 32'h0);
    end

    // All three channels idle together: simultaneous pulses.
    driveInputs(0, 2'b00, 3'b000, 3'b111, 3'b111, 0, 0);
    stepEdge();
    driveInputs(0, 2'b00, 3'b000, 3'b000, 3'b000, 0, 0);
    for (int e = 1; e <= 30; e++) begin
      stepEdge();
      if (e >= 29) begin
        checkOutput($sformatf("simul_e%0d", e), 32'(softReset),
                    (e == 30) ? 32'h7 : 32'h0);
      end
    end

    // Flush of the latched channel pulls WAIT_EMPTY back to DECODE.
    driveInputs(0, 2'b00, 3'b000, 3'b111, 3'b111, 0, 0);
    stepEdge();
    driveInputs(1, 2'b01, 3'b000, 3'b101, 3'b000, 0, 0);
    stepEdge();
    checkOutput("sr_wait_entry", 32'(outVec()), 32'({S_WAIT, 1'b0, 3'b000}));
    driveInputs(0, 2'b01, 3'b000, 3'b101, 3'b000, 0, 0);
    for (int e = 2; e <= 30; e++) begin
      stepEdge();
    end
    checkOutput("sr_pulse", 32'(softReset), 32'h2);
    checkOutput("sr_still_wait", 32'(outVec()), 32'({S_WAIT, 1'b0, 3'b000}));
    stepEdge();
    checkOutput("sr_forced_decode", 32'(outVec()), 32'({S_DEC, 1'b0, 3'b000}));
    driveInputs(0, 2'b00, 3'b000, 3'b111, 3'b111, 0, 0);
    stepEdge();
`else
    // Feature absent: soft_reset never fires and WAIT_EMPTY holds.
    driveInputs(1, 2'b01, 3'b000, 3'b000, 3'b000, 0, 0);
    stepEdge();
    driveInputs(0, 2'b01, 3'b000, 3'b000, 3'b000, 0, 0);
    checkOutput("vld_out_all", 32'(vldOut), 32'h7);
    for (int e = 2; e <= 36; e++) begin
      stepEdge();
      if (e % 5 == 0) begin
        checkOutput($sformatf("no_soft_e%0d", e), 32'(softReset), 32'h0);
      end
    end
    checkOutput("wait_held", 32'(outVec()), 32'({S_WAIT, 1'b0, 3'b000}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 30: idle-valid cycles before a channel soft reset.
REQ-002 SHALL have port clk  input  1  single clock; all flops rise-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pkt_valid  input  1  packet byte valid on data_in.
REQ-005 SHALL have port data_in  input  2  header address bits [1:0].
REQ-006 SHALL have port fifo_full_in  input  3  per-channel output FIFO full.
REQ-007 SHALL have port fifo_empty  input  3  per-channel output FIFO empty.
REQ-008 SHALL have port read_enb  input  3  per-channel downstream read strobe.
REQ-009 SHALL have port parity_done, low_pkt_valid  input  1 each  status from the packet register.
REQ-010 SHALL have port fifo_full  output  1  full flag of the latched channel.
REQ-011 SHALL have port write_enb  output  3  one-hot FIFO write enable.
REQ-012 SHALL have port vld_out  output  3  ~fifo_empty per channel.
REQ-013 SHALL have port soft_reset  output  3  per-channel timeout flush pulse.
REQ-014 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy  output  1 each  state decodes.

Function
REQ-015 SHALL implement Moore FSM: DECODE, WAIT_EMPTY, LFD, LOAD_DATA, FIFO_FULL, LAF, LOAD_PARITY, CHECK_PARITY.
REQ-016 DECODE: pkt_valid & addr!=3 & fifo_empty[addr] -> LFD; pkt_valid & addr!=3 & ~empty -> WAIT_EMPTY; addr==3 or ~pkt_valid -> stay.
REQ-017 SHALL latch data_in into addr register on DECODE & pkt_valid & data_in!=3; addr 3 dropped, no writes.
REQ-018 WAIT_EMPTY -> LFD when fifo_empty[addr]; else stay.
REQ-019 LFD -> LOAD_DATA unconditionally.
REQ-020 LOAD_DATA: fifo_full -> FIFO_FULL; ~fifo_full & ~pkt_valid -> LOAD_PARITY; else stay.
REQ-021 FIFO_FULL: ~fifo_full -> LAF; else stay.
REQ-022 LAF: parity_done -> DECODE; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-023 LOAD_PARITY -> CHECK_PARITY; CHECK_PARITY: fifo_full -> FIFO_FULL, else DECODE.
REQ-024 soft_reset[addr] asserted in any state SHALL force next state DECODE, overriding REQ-016..023.
REQ-025 Decodes combinational from state: detect_add=DECODE, lfd_state=LFD, ld_state=LOAD_DATA, laf_state=LAF, full_state=FIFO_FULL, rst_int_reg=CHECK_PARITY.
REQ-026 busy SHALL be 1 in all states except DECODE and LOAD_DATA.
REQ-027 write_enb SHALL equal onehot(addr) when state in {LOAD_DATA, LAF, LOAD_PARITY}, else 3'b000.
REQ-028 fifo_full SHALL equal fifo_full_in[addr], combinational.
REQ-029 Per channel i: counter increments while vld_out[i] & ~read_enb[i]; clears on read_enb[i] or ~vld_out[i].
REQ-030 Counter reaching TIMEOUT-1 SHALL pulse soft_reset[i] one cycle and clear; counter width $clog2(TIMEOUT)+1.
REQ-031 Three timers SHALL run independently; simultaneous timeouts pulse simultaneously.

Reset
REQ-032 reset SHALL asynchronously force state DECODE, addr 2'b00, all counters 0, soft_reset 3'b000.
REQ-033 Post-reset outputs: detect_add=1, other decodes 0, busy=0, write_enb=0.
REQ-034 Reset mid-packet SHALL abandon packet; no write_enb until next DECODE acceptance.

Configuration
REQ-035 Macro ROUTER_SOFT_RESET_EN defined: timers and REQ-024 present.
REQ-036 Macro undefined: no timer logic, soft_reset tied 3'b000, REQ-024 inert.

Structure
REQ-037 Package router_pkg SHALL hold state enum, ADDR_INVALID=2'b11, default TIMEOUT.
REQ-038 Sub-module router_timeout_ctr (one channel counter) SHALL be instantiated three times.

Verification
REQ-039 Reset, pkt_valid=1 data_in=01, fifo_empty=111 -> LFD next cycle, then LOAD_DATA with write_enb=010.
REQ-040 data_in=11 with pkt_valid=1 -> stays DECODE, write_enb=000, addr unchanged.
REQ-041 addr=00, fifo_empty[0]=0 -> WAIT_EMPTY, busy=1; empty[0] rises -> LFD next cycle.
REQ-042 LOAD_DATA, fifo_full_in[2]=1 (addr=10) -> FIFO_FULL, write_enb=000; release -> LAF, parity_done=0 low_pkt_valid=1 -> LOAD_PARITY -> CHECK_PARITY (rst_int_reg=1) -> DECODE.
REQ-043 fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1] one-cycle pulse on 30th; read_enb[1] at cycle 29 -> no pulse.
REQ-044 reset asserted mid-LOAD_DATA -> DECODE immediately, asynchronously; write_enb=000 same cycle.
